// File: rtl/sdhci_cmd_pkg.sv
// Shared types and constants for the SDHCI command-line engine.
//   state_e     : command engine FSM states
//   resp_type_e : response type encoding from the command register
//   cmd_req_t   : command fields latched when a command is accepted
package sdhci_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX,
    NCR_WAIT,
    RX,
    NCC,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_136  = 2'b01,
    RESP_48   = 2'b10,
    RESP_48B  = 2'b11
  } resp_type_e;

  localparam int FrameLen   = 48;   // command frame and short response length
  localparam int RespLen136 = 136;  // long (CID/CSD) response length
  localparam int CrcSpan48  = 40;   // bits covered by CRC7 in a 48-bit frame
  localparam int NccClocks  = 8;

  typedef struct packed {
    logic [5:0]  index;
    logic [31:0] arg;
    resp_type_e  resp_type;
    logic        crc_chk;
    logic        idx_chk;
  } cmd_req_t;

  // Last bit position (0 = start bit) of the response frame.
  function automatic logic [7:0] resp_last(input resp_type_e rt);
    return (rt == RESP_136) ? 8'(RespLen136 - 1) : 8'(FrameLen - 1);
  endfunction

endpackage

// File: rtl/sdhci_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0), one message bit per enabled cycle.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear        : return the remainder to 0 (wins over en)
//   en, bit_in   : shift one message bit in, MSB first
//   crc_o        : current remainder
module sdhci_crc7 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [6:0] crc_o
);

  logic fb;
  assign fb = bit_in ^ crc_o[6];

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) crc_o <= '0;
    else if (en)        crc_o <= {crc_o[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  end

endmodule

// File: rtl/sdhci_cmd_engine.sv
// SD CMD-line engine: generates the SD clock, serialises a 48-bit command
// frame with CRC7, then receives and checks the card response.
//   clk_i, rst_i        : system clock, synchronous active-high reset
//   start_i + cmd fields: command issue (ignored while a command is in flight)
//   busy_o, done_o      : in-flight flag, one-cycle completion pulse
//   response_o          : response payload, updated on response completion
//   *_err_o             : error flags, published with done_o, held until next start
//   sd_clk_o, sd_cmd_*  : SD clock and CMD pad
module sdhci_cmd_engine
  import sdhci_cmd_pkg::*;
#(
  parameter int ClkDiv = 4,
  parameter int NcrMax = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  argument_i,
  input  logic [1:0]   resp_type_i,
  input  logic         crc_check_en_i,
  input  logic         index_check_en_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] response_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o,
  output logic         sd_clk_o,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe_o,
  input  logic         sd_cmd_i
);

  localparam int DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam int NcrW = $clog2(NcrMax + 1);

  // ---------------- SD clock ----------------
  logic [DivW-1:0] div_cnt;
  logic            tick, fall, rise;

  assign tick = (div_cnt == DivW'(ClkDiv - 1));
  assign fall = tick & sd_clk_o;   // sd_clk_o goes low at this edge
  assign rise = tick & ~sd_clk_o;  // sd_clk_o goes high at this edge

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt  <= '0;
      sd_clk_o <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      sd_clk_o <= ~sd_clk_o;
    end else begin
      div_cnt  <= div_cnt + DivW'(1);
    end
  end

  // ---------------- state ----------------
  state_e          state_q, state_d;
  cmd_req_t        req;
  logic [39:0]     tx_sh;     // 0,1,index,arg still to be sent, MSB first
  logic [7:0]      bit_cnt;   // TX bit / RX bit position / NCC rise count
  logic [NcrW-1:0] ncr_cnt;
  logic [126:0]    rx_sh;
  logic [127:0]    rx_full;   // received bits including the one sampled now
  logic [3:0]      pend;      // {timeout, crc, end_bit, index}, published at DONE
  logic [6:0]      tx_crc, rx_crc;
  logic            tx_bit, is136, ncr_last, rx_last, tx_crc_en, rx_crc_en;
  logic [7:0]      rx_lo, rx_hi;
  logic            crc_bad, idx_bad, end_bad;
  logic            accept;

  assign accept   = (state_q == IDLE) && start_i;
  assign is136    = (req.resp_type == RESP_136);
  assign ncr_last = (ncr_cnt == NcrW'(NcrMax - 1));
  assign rx_last  = (bit_cnt == resp_last(req.resp_type));
  assign rx_full  = {rx_sh, sd_cmd_i};
  // Long responses skip start, transmission and reserved bits in the CRC.
  assign rx_lo    = is136 ? 8'd8 : 8'd0;
  assign rx_hi    = is136 ? 8'd127 : 8'd39;

  assign busy_o = (state_q == TX) || (state_q == NCR_WAIT) ||
                  (state_q == RX) || (state_q == NCC);
  assign done_o = (state_q == DONE);

  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < 8'(CrcSpan48))     tx_bit = tx_sh[39];
    else if (bit_cnt < 8'(FrameLen - 1)) tx_bit = tx_crc[3'(8'd46 - bit_cnt)];
  end

  assign tx_crc_en = (state_q == TX) && fall && (bit_cnt < 8'(CrcSpan48));
  // The start bit arrives in NCR_WAIT; it is part of the short-response CRC.
  assign rx_crc_en = rise && (((state_q == NCR_WAIT) && !sd_cmd_i && !is136) ||
                              ((state_q == RX) && (bit_cnt >= rx_lo) && (bit_cnt <= rx_hi)));

  assign crc_bad = req.crc_chk && (rx_full[7:1] != rx_crc);
  assign idx_bad = !is136 && req.idx_chk && (rx_full[45:40] != req.index);
  assign end_bad = !is136 && (rx_full[46] || !rx_full[0]);

  sdhci_crc7 u_tx_crc (
    .clk_i(clk_i), .rst_i(rst_i), .clear(accept), .en(tx_crc_en),
    .bit_in(tx_sh[39]), .crc_o(tx_crc)
  );

  sdhci_crc7 u_rx_crc (
    .clk_i(clk_i), .rst_i(rst_i), .clear(accept), .en(rx_crc_en),
    .bit_in(sd_cmd_i), .crc_o(rx_crc)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start_i) state_d = TX;
      TX:       if (fall && bit_cnt == 8'(FrameLen))
                  state_d = (req.resp_type == RESP_NONE) ? NCC : NCR_WAIT;
      NCR_WAIT: if (rise) begin
                  if (!sd_cmd_i)    state_d = RX;
                  else if (ncr_last) state_d = NCC;
                end
      RX:       if (rise && rx_last) state_d = NCC;
      NCC:      if (rise && bit_cnt == 8'(NccClocks - 1)) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req           <= '0;
      tx_sh         <= '0;
      bit_cnt       <= '0;
      ncr_cnt       <= '0;
      rx_sh         <= '0;
      pend          <= '0;
      response_o    <= '0;
      sd_cmd_o      <= 1'b1;
      sd_cmd_oe_o   <= 1'b0;
      timeout_err_o <= 1'b0;
      crc_err_o     <= 1'b0;
      end_bit_err_o <= 1'b0;
      index_err_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          req           <= '{index: cmd_index_i, arg: argument_i,
                             resp_type: resp_type_e'(resp_type_i),
                             crc_chk: crc_check_en_i, idx_chk: index_check_en_i};
          tx_sh         <= {2'b01, cmd_index_i, argument_i};
          bit_cnt       <= '0;
          pend          <= '0;
          timeout_err_o <= 1'b0;
          crc_err_o     <= 1'b0;
          end_bit_err_o <= 1'b0;
          index_err_o   <= 1'b0;
        end
        TX: if (fall) begin
          if (bit_cnt == 8'(FrameLen)) begin
            sd_cmd_oe_o <= 1'b0;
            sd_cmd_o    <= 1'b1;
            bit_cnt     <= '0;
            ncr_cnt     <= '0;
          end else begin
            sd_cmd_oe_o <= 1'b1;
            sd_cmd_o    <= tx_bit;
            bit_cnt     <= bit_cnt + 8'd1;
            if (bit_cnt < 8'(CrcSpan48)) tx_sh <= {tx_sh[38:0], 1'b0};
          end
        end
        NCR_WAIT: if (rise) begin
          if (!sd_cmd_i) begin
            rx_sh   <= '0;      // start bit already counted
            bit_cnt <= 8'd1;
          end else if (ncr_last) begin
            pend[3] <= 1'b1;
            bit_cnt <= '0;
          end else begin
            ncr_cnt <= ncr_cnt + NcrW'(1);
          end
        end
        RX: if (rise) begin
          rx_sh <= rx_full[126:0];
          if (rx_last) begin
            bit_cnt    <= '0;
            pend[2:0]  <= {crc_bad, end_bad, idx_bad};
            response_o <= is136 ? {8'h00, rx_full[127:8]} : {96'h0, rx_full[39:8]};
          end else begin
            bit_cnt <= bit_cnt + 8'd1;
          end
        end
        NCC: if (rise) begin
          bit_cnt <= bit_cnt + 8'd1;
          // Flags become visible in the same cycle done_o rises.
          if (bit_cnt == 8'(NccClocks - 1))
            {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o} <= pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdhci_cmd_engine.sv
module tb_sdhci_cmd_engine;

  localparam int NcrMax = 64;

  logic         clk = 1'b0;
  logic         rst_i, start_i, crc_check_en_i, index_check_en_i, sd_cmd_i;
  logic [5:0]   cmd_index_i;
  logic [31:0]  argument_i;
  logic [1:0]   resp_type_i;
  logic         busy_o, done_o, timeout_err_o, crc_err_o, end_bit_err_o, index_err_o;
  logic [127:0] response_o;
  logic         sd_clk_o, sd_cmd_o, sd_cmd_oe_o;
  logic [3:0]   flags;

  assign flags = {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o};

  always #5 clk = ~clk;

  sdhci_cmd_engine #(.ClkDiv(4), .NcrMax(NcrMax)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cmd_index_i(cmd_index_i),
    .argument_i(argument_i), .resp_type_i(resp_type_i),
    .crc_check_en_i(crc_check_en_i), .index_check_en_i(index_check_en_i),
    .busy_o(busy_o), .done_o(done_o), .response_o(response_o),
    .timeout_err_o(timeout_err_o), .crc_err_o(crc_err_o),
    .end_bit_err_o(end_bit_err_o), .index_err_o(index_err_o),
    .sd_clk_o(sd_clk_o), .sd_cmd_o(sd_cmd_o), .sd_cmd_oe_o(sd_cmd_oe_o),
    .sd_cmd_i(sd_cmd_i)
  );

  typedef struct {
    string        name;
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rt;
    logic         ce, ie;
    int           rlen;       // 0 = card stays silent
    logic [135:0] resp;       // card response, MSB at [rlen-1]
    int           ncr;        // SD clocks the card waits before its start bit
    bit           mid_start;
    logic [47:0]  exp_frame;
    logic [127:0] exp_response;
    logic [3:0]   exp_err;    // {timeout, crc, end_bit, index}
  } vec_t;

  int total = 0, bad = 0;
  logic sdclk_prev = 1'b0;
  bit rise_now, fall_now;
  logic [127:0] prior;

  task automatic chk(input string n, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // One system cycle; DUT outputs are sampled on the falling clk edge.
  task automatic step();
    @(negedge clk);
    rise_now   = sd_clk_o && !sdclk_prev;
    fall_now   = !sd_clk_o && sdclk_prev;
    sdclk_prev = sd_clk_o;
  endtask

  // Remainder of msg[n-1:0]*x^7 modulo x^7+x^3+1, by long division.
  function automatic logic [6:0] crc7(input logic [127:0] msg, input int n);
    logic [134:0] m;
    logic [7:0]   poly;
    poly = 8'h89;
    m = '0;
    for (int i = 0; i < n; i++) m[i+7] = msg[i];
    for (int i = n + 6; i >= 7; i--)
      if (m[i]) for (int j = 0; j < 8; j++) if (poly[j]) m[i-7+j] = ~m[i-7+j];
    return m[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7({88'h0, h}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk48(input logic tbit, input logic [5:0] idx,
                                        input logic [31:0] stat, input bit flip, input logic endb);
    logic [39:0] h;
    logic [6:0]  c;
    h = {1'b0, tbit, idx, stat};
    c = crc7({88'h0, h}, 40) ^ (flip ? 7'h01 : 7'h00);
    return {88'h0, h, c, endb};
  endfunction

  function automatic logic [135:0] mk136(input logic [119:0] cid, input bit flip);
    logic [6:0] c;
    c = crc7({8'h0, cid}, 120) ^ (flip ? 7'h01 : 7'h00);
    return {2'b00, 6'h3F, cid, c, 1'b1};
  endfunction

  // Reference model: expected frame, response and flags from the command rules.
  function automatic vec_t model(input vec_t v, input logic [127:0] pr);
    vec_t o;
    o = v;
    o.exp_frame    = mk_frame(v.idx, v.arg);
    o.exp_response = pr;
    o.exp_err      = '0;
    if (v.rt != 2'b00) begin
      if (v.rlen == 0) o.exp_err[3] = 1'b1;
      else if (v.rt == 2'b01) begin
        o.exp_response = {8'h0, v.resp[127:8]};
        o.exp_err[2]   = v.ce && (v.resp[7:1] != crc7(v.resp[127:8], 120));
      end else begin
        o.exp_response = {96'h0, v.resp[39:8]};
        o.exp_err[2]   = v.ce && (v.resp[7:1] != crc7({88'h0, v.resp[47:8]}, 40));
        o.exp_err[1]   = v.resp[46] || !v.resp[0];
        o.exp_err[0]   = v.ie && (v.resp[45:40] != v.idx);
      end
    end
    return o;
  endfunction

  task automatic run_cmd(input vec_t v);
    logic [47:0] txw;
    int ntx, post, cbit, busy_gap, exp_post, stray;
    bit card_on, card_done, got_done, ms_done;
    txw = '0; ntx = 0; post = 0; cbit = 0; busy_gap = 0; stray = 0;
    card_on = 0; card_done = 0; got_done = 0; ms_done = 0;
    cmd_index_i = v.idx; argument_i = v.arg; resp_type_i = v.rt;
    crc_check_en_i = v.ce; index_check_en_i = v.ie;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({v.name, "/busy_t1"}, busy_o, 1'b1);
    chk({v.name, "/flags_cleared"}, flags, 4'h0);
    for (int c = 0; c < 4000 && !got_done; c++) begin
      step();
      start_i = 1'b0;
      cmd_index_i = v.idx;
      if (rise_now) begin
        if (sd_cmd_oe_o) begin txw = {txw[46:0], sd_cmd_o}; ntx++; end
        else if (ntx >= 48) post++;
      end
      // Card drives on SD-clock falls once the host has released the line.
      if (fall_now && v.rlen > 0 && ntx >= 48 && !sd_cmd_oe_o) begin
        if (card_on) begin
          if (cbit < v.rlen) begin sd_cmd_i = v.resp[v.rlen-1-cbit]; cbit++; end
          else begin sd_cmd_i = 1'b1; card_on = 0; card_done = 1; end
        end else if (!card_done && post == v.ncr) begin
          card_on = 1; sd_cmd_i = v.resp[v.rlen-1]; cbit = 1;
        end
      end
      if (v.mid_start && card_on && cbit == 20 && !ms_done) begin
        start_i = 1'b1; cmd_index_i = ~v.idx; ms_done = 1;
      end
      if (done_o) got_done = 1;
      else if (!busy_o) busy_gap++;
    end
    start_i = 1'b0;
    chk({v.name, "/done_seen"}, got_done, 1'b1);
    chk({v.name, "/busy_held"}, busy_gap, 0);
    chk({v.name, "/tx_bits"}, ntx, 48);
    chk({v.name, "/tx_frame"}, txw, v.exp_frame);
    chk({v.name, "/flags"}, flags, v.exp_err);
    chk({v.name, "/response"}, response_o, v.exp_response);
    exp_post = (v.rt == 2'b00) ? 8 : (v.rlen == 0) ? NcrMax + 8 : v.ncr + v.rlen + 8;
    chk({v.name, "/sd_clocks_after_tx"}, post, exp_post);
    step();
    chk({v.name, "/done_one_cycle"}, {done_o, busy_o}, 2'b00);
    chk({v.name, "/flags_held"}, flags, v.exp_err);
    if (v.mid_start) begin
      for (int c = 0; c < 80; c++) begin
        step();
        if (busy_o || sd_cmd_oe_o) stray++;
      end
      chk({v.name, "/ignored_start"}, stray, 0);
    end
    sd_cmd_i = 1'b1;
    prior = v.exp_response;
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    logic [31:0]  stat;
    logic [119:0] cid, cid2;
    int n, stray;
    stat = 32'h0000_0900;
    cid  = 120'h035344534431364780123456780139;
    cid2 = 120'h400E00325B590000EE7F7F800A4000;
    rst_i = 1'b1; start_i = 1'b0; sd_cmd_i = 1'b1; cmd_index_i = '0;
    argument_i = '0; resp_type_i = '0; crc_check_en_i = 1'b0; index_check_en_i = 1'b0;

    //         name         idx    arg            rt     ce ie rlen resp                         ncr ms frame                      response                 err
    tbl[0]  = '{"cmd0",     6'd0,  32'h0,         2'b00, 1, 1, 0,   '0,                          1, 0, 48'h400000000095,          128'h0,                  4'b0000};
    tbl[1]  = '{"cmd8",     6'd8,  32'h1AA,       2'b10, 1, 1, 48,  136'h08000001AA13,           2, 0, 48'h48000001AA87,          128'h1AA,                4'b0000};
    tbl[2]  = '{"cmd17_to", 6'd17, 32'h200,       2'b10, 1, 1, 0,   '0,                          1, 0, mk_frame(6'd17, 32'h200),  128'h1AA,                4'b1000};
    tbl[3]  = '{"r1_crc",   6'd13, 32'h10000,     2'b10, 1, 1, 48,  mk48(0, 6'd13, stat, 1, 1),  3, 0, mk_frame(6'd13, 32'h10000), {96'h0, stat},          4'b0100};
    tbl[4]  = '{"r1_idx",   6'd13, 32'h10000,     2'b10, 1, 1, 48,  mk48(0, 6'd14, stat, 0, 1),  1, 0, mk_frame(6'd13, 32'h10000), {96'h0, stat},          4'b0001};
    tbl[5]  = '{"r1_crc_off",6'd13,32'h10000,     2'b10, 0, 1, 48,  mk48(0, 6'd13, stat, 1, 1),  4, 0, mk_frame(6'd13, 32'h10000), {96'h0, stat},          4'b0000};
    tbl[6]  = '{"r1_idx_off",6'd13,32'h10000,     2'b10, 1, 0, 48,  mk48(0, 6'd14, stat, 0, 1),  2, 0, mk_frame(6'd13, 32'h10000), {96'h0, stat},          4'b0000};
    tbl[7]  = '{"r1_endbit",6'd55, 32'hDEADBEEF,  2'b10, 1, 1, 48,  mk48(0, 6'd55, 32'h120, 0, 0), 1, 0, mk_frame(6'd55, 32'hDEADBEEF), 128'h120,         4'b0010};
    tbl[8]  = '{"r1_tbit",  6'd55, 32'h1,         2'b10, 1, 1, 48,  mk48(1, 6'd55, 32'h920, 0, 1), 5, 0, mk_frame(6'd55, 32'h1),    128'h920,                4'b0010};
    tbl[9]  = '{"cmd2_r2",  6'd2,  32'h0,         2'b01, 1, 1, 136, mk136(cid, 0),               2, 1, mk_frame(6'd2, 32'h0),     {8'h0, cid},             4'b0000};
    tbl[10] = '{"cmd9_crc", 6'd9,  32'h12340000,  2'b01, 1, 0, 136, mk136(cid2, 1),              3, 0, mk_frame(6'd9, 32'h12340000), {8'h0, cid2},         4'b0100};
    tbl[11] = '{"cmd7_r1b", 6'd7,  32'h12340000,  2'b11, 1, 1, 48,  mk48(0, 6'd7, 32'h700, 0, 1), 1, 0, mk_frame(6'd7, 32'h12340000), 128'h700,            4'b0000};

    repeat (3) step();
    chk("reset/outputs", {busy_o, done_o, flags, sd_clk_o, sd_cmd_oe_o, sd_cmd_o}, 9'b000000001);
    chk("reset/response", response_o, 128'h0);
    rst_i = 1'b0;
    prior = '0;

    foreach (tbl[i]) run_cmd(tbl[i]);

    // Random commands checked against the reference model.
    for (int r = 0; r < 8; r++) begin
      int mode;
      rv = tbl[0];
      rv.name = $sformatf("rand%0d", r);
      rv.idx = 6'($urandom_range(0, 63));
      rv.arg = $urandom;
      rv.rt  = 2'($urandom_range(0, 3));
      rv.ce  = 1'($urandom_range(0, 1));
      rv.ie  = 1'($urandom_range(0, 1));
      rv.ncr = $urandom_range(1, 6);
      rv.mid_start = 0;
      mode = $urandom_range(0, 4);
      if (rv.rt == 2'b00 || mode == 0) begin
        rv.rlen = 0; rv.resp = '0;
      end else if (rv.rt == 2'b01) begin
        rv.rlen = 136;
        rv.resp = mk136({$urandom, $urandom, $urandom, 24'($urandom)}, mode == 2);
      end else begin
        rv.rlen = 48;
        rv.resp = mk48(mode == 4, (mode == 3) ? ~rv.idx : rv.idx, $urandom, mode == 2,
                       (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1);
      end
      run_cmd(model(rv, prior));
    end

    // Reset in the middle of the command frame.
    cmd_index_i = 6'd17; argument_i = 32'h55; resp_type_i = 2'b10;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    for (int c = 0; c < 2000 && n < 10; c++) begin
      step();
      if (rise_now && sd_cmd_oe_o) n++;
    end
    chk("rst/mid_tx_reached", n, 10);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst/outputs", {busy_o, done_o, flags, sd_cmd_oe_o, sd_cmd_o}, 8'b00000001);
    chk("rst/response", response_o, 128'h0);
    stray = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (done_o || busy_o || sd_cmd_oe_o) stray++;
    end
    chk("rst/no_done_after", stray, 0);
    prior = '0;
    run_cmd(tbl[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
